// File: rtl/sha2_pkg.sv
// Shared SHA-2 schedule definitions: per-width sigma rotate/shift amounts, round
// counts, the schedule FSM state type and the small-sigma functions.
package sha2_pkg;

  localparam int unsigned MSG_IDX_W = 7;
  localparam int unsigned ROUNDS_32 = 64;
  localparam int unsigned ROUNDS_64 = 80;

  localparam int unsigned S0_ROT_A_32 = 7;
  localparam int unsigned S0_ROT_B_32 = 18;
  localparam int unsigned S0_SHR_32   = 3;
  localparam int unsigned S1_ROT_A_32 = 17;
  localparam int unsigned S1_ROT_B_32 = 19;
  localparam int unsigned S1_SHR_32   = 10;

  localparam int unsigned S0_ROT_A_64 = 1;
  localparam int unsigned S0_ROT_B_64 = 8;
  localparam int unsigned S0_SHR_64   = 7;
  localparam int unsigned S1_ROT_A_64 = 19;
  localparam int unsigned S1_ROT_B_64 = 61;
  localparam int unsigned S1_SHR_64   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND
  } msg_sched_state_t;

  function automatic int unsigned rounds_for(input int unsigned width);
    return (width == 64) ? ROUNDS_64 : ROUNDS_32;
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sigma0_32(input logic [31:0] x);
    return rotr32(x, S0_ROT_A_32) ^ rotr32(x, S0_ROT_B_32) ^ (x >> S0_SHR_32);
  endfunction

  function automatic logic [31:0] sigma1_32(input logic [31:0] x);
    return rotr32(x, S1_ROT_A_32) ^ rotr32(x, S1_ROT_B_32) ^ (x >> S1_SHR_32);
  endfunction

  function automatic logic [63:0] sigma0_64(input logic [63:0] x);
    return rotr64(x, S0_ROT_A_64) ^ rotr64(x, S0_ROT_B_64) ^ (x >> S0_SHR_64);
  endfunction

  function automatic logic [63:0] sigma1_64(input logic [63:0] x);
    return rotr64(x, S1_ROT_A_64) ^ rotr64(x, S1_ROT_B_64) ^ (x >> S1_SHR_64);
  endfunction

endpackage

// File: rtl/msg_sched_next.sv
// Combinational schedule recurrence: new = s1(w14) + w9 + s0(w1) + w0 mod 2^WORD_W.
module msg_sched_next
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] w14,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w0,
  output logic [WORD_W-1:0] new_word
);

  if (WORD_W == 64) begin : g_sha512
    assign new_word = sigma1_64(w14) + w9 + sigma0_64(w1) + w0;
  end else begin : g_sha256
    assign new_word = sigma1_32(w14) + w9 + sigma0_32(w1) + w0;
  end

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: serial 16-word load, then W[0..ROUNDS-1] out.
// Optional abort input enabled by defining MSG_SCHEDULE_ABORT_EN.
module msg_schedule
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MSG_SCHEDULE_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic [MSG_IDX_W-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned ROUNDS = rounds_for(WORD_W);
  localparam int unsigned IDX_W  = MSG_IDX_W;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("msg_schedule: WORD_W must be 32 or 64");
  end

  msg_sched_state_t  state, state_next;
  logic [WORD_W-1:0] window [16];
  logic [WORD_W-1:0] new_word;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  round;
  logic              accept, xfer, abort_clr;

  msg_sched_next #(.WORD_W(WORD_W)) u_next (
    .w14      (window[14]),
    .w9       (window[9]),
    .w1       (window[1]),
    .w0       (window[0]),
    .new_word (new_word)
  );

  always_comb begin
    state_next = state;
    abort_clr  = 1'b0;
    in_ready   = (state != ST_EXPAND);
    out_valid  = (state == ST_EXPAND);
    busy       = (state != ST_IDLE);
    out_word   = out_valid ? window[0] : '0;
    out_idx    = round;
    out_last   = out_valid && (round == IDX_W'(ROUNDS - 1));
    accept     = in_valid && in_ready;
    xfer       = out_valid && out_ready;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_LOAD;
      ST_LOAD:   if (accept && cnt == 4'd15) state_next = ST_EXPAND;
      ST_EXPAND: if (xfer && out_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
`ifdef MSG_SCHEDULE_ABORT_EN
    // A same-cycle output handshake still shifts the window; only control is cancelled.
    if (abort && state != ST_IDLE) begin
      state_next = ST_IDLE;
      abort_clr  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      round <= '0;
      for (int unsigned i = 0; i < 16; i++) window[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) window[cnt] <= in_word;
      if (xfer) begin
        for (int unsigned i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= new_word;
      end
      if (abort_clr) begin
        cnt   <= '0;
        round <= '0;
      end else begin
        // cnt wraps 15 -> 0 on the final load word, leaving it clear for the next block.
        if (accept) cnt <= cnt + 4'd1;
        if (xfer) round <= out_last ? '0 : round + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule (32-bit and 64-bit instances).
module tb_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0] in_word, out_word;
  logic [6:0]  out_idx;
`ifdef MSG_SCHEDULE_ABORT_EN
  logic        abort;
  logic        abort64;
`endif

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_last64, busy64;
  logic [63:0] in_word64, out_word64;
  logic [6:0]  out_idx64;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] fill;
    logic [31:0] w15;
    logic [31:0] exp16;
    logic [31:0] exp17;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  msg_schedule #(.WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MSG_SCHEDULE_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  msg_schedule #(.WORD_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
`ifdef MSG_SCHEDULE_ABORT_EN
    .abort(abort64),
`endif
    .in_valid(in_valid64), .in_ready(in_ready64), .in_word(in_word64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_word(out_word64),
    .out_idx(out_idx64), .out_last(out_last64), .busy(busy64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook recurrence over the full W[] array.
  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic load_block(input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  v;
    while (i < 16 && guard < 1000) begin
      @(negedge clk);
      guard++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_word  = blk[i];
      if (v && in_ready) i++;
    end
    if (i < 16) check("load_timeout", 64'(i), 64'd16);
    @(negedge clk);
    in_valid = 1'b0;
    check("out_valid_after_load", 64'(out_valid), 64'd1);
    check("busy_after_load", 64'(busy), 64'd1);
  endtask

  task automatic run_expand(input bit stall, input bit junk);
    int          n = 0;
    int          guard = 0;
    bit          held = 1'b0;
    bit          r;
    logic [31:0] pw;
    logic [6:0]  pi;
    while (n < 64 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (held) begin
        check("stall_word", 64'(out_word), 64'(pw));
        check("stall_idx", 64'(out_idx), 64'(pi));
      end
      check("in_ready_expand", 64'(in_ready), 64'd0);
      r = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = r;
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        in_word  = $urandom;
      end
      if (out_valid && r) begin
        got_w[n] = out_word;
        check("word", 64'(out_word), 64'(exp_w[n]));
        check("idx", 64'(out_idx), 64'(n));
        check("last", 64'(out_last), 64'(n == 63));
        n++;
        held = 1'b0;
      end else begin
        held = out_valid;
        pw   = out_word;
        pi   = out_idx;
      end
    end
    if (n < 64) check("expand_timeout", 64'(n), 64'd64);
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
  endtask

  initial begin
    int n;
    int g;
    rst_n = 1'b0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    in_valid64 = 1'b0; in_word64 = '0; out_ready64 = 1'b0;
`ifdef MSG_SCHEDULE_ABORT_EN
    abort = 1'b0; abort64 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready64", 64'(in_ready64), 64'd1);

    // WORD_W = 64, all-zero block: 80 zero words, out_last at 79
    n = 0;
    g = 0;
    in_valid64 = 1'b1;
    while (n < 16 && g < 100) begin
      if (in_ready64) n++;
      @(negedge clk);
      g++;
    end
    in_valid64 = 1'b0;
    out_ready64 = 1'b1;
    n = 0;
    g = 0;
    while (n < 80 && g < 300) begin
      if (out_valid64) begin
        check("w64_word", out_word64, 64'd0);
        check("w64_idx", 64'(out_idx64), 64'(n));
        check("w64_last", 64'(out_last64), 64'(n == 79));
        n++;
      end
      @(negedge clk);
      g++;
    end
    check("w64_count", 64'(n), 64'd80);
    check("w64_idle_valid", 64'(out_valid64), 64'd0);
    check("w64_idle_ready", 64'(in_ready64), 64'd1);
    out_ready64 = 1'b0;

    // Directed blocks: W0, W1..W14 = fill, W15 with known W[16], W[17]
    tbl[0] = '{32'h61626380, 32'h0, 32'h00000018, 32'h61626380, 32'h000F0000};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h203FFFFC, 32'h203FFFFC};
    tbl[2] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{32'h00000001, 32'h0, 32'h0, 32'h00000001, 32'h0};
    for (int k = 0; k < 4; k++) begin
      blk[0] = tbl[k].w0;
      for (int i = 1; i < 15; i++) blk[i] = tbl[k].fill;
      blk[15] = tbl[k].w15;
      build_model();
      load_block(1'b0);
      run_expand(1'b0, 1'b0);
      check("tbl_w16", 64'(got_w[16]), 64'(tbl[k].exp16));
      check("tbl_w17", 64'(got_w[17]), 64'(tbl[k].exp17));
    end

    // Random blocks with input gaps, output stalls and junk in_valid during expand
    for (int k = 0; k < 4; k++) begin
      random_block();
      load_block(1'b1);
      run_expand(1'b1, 1'b1);
    end

    // Reset asserted at round 30
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = '0;
    blk[15] = 32'h18;
    load_block(1'b0);
    out_ready = 1'b1;
    g = 0;
    while (out_idx != 7'd30 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("reach_round30", 64'(out_idx), 64'd30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_word", 64'(out_word), 64'd0);
    check("mid_rst_out_idx", 64'(out_idx), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    random_block();
    load_block(1'b0);
    run_expand(1'b0, 1'b0);

`ifdef MSG_SCHEDULE_ABORT_EN
    random_block();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = blk[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    random_block();
    load_block(1'b0);
    run_expand(1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_schedule.md
# msg_schedule

Parametrised message-schedule expander for the SHA-2 hashing datapath. It accepts one 16-word message block serially and streams the expanded schedule W[0..ROUNDS-1] one word per cycle to the compression core. It generalises the existing small-sigma function blocks: both σ0 and σ1 are built in, the word width is selectable, and load/expand sequencing uses valid/ready handshakes.

## Interface
- WORD_W, default 32: word width.
  - 32 selects SHA-256 constants, ROUNDS = 64.
  - 64 selects SHA-512 constants, ROUNDS = 80.
  - Any other value is a compile-time error.
- ROUNDS, derived localparam: 64 or 80, not overridable.
- IDX_W, derived localparam: 7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts an input word.
- in_word  in  WORD_W  message word, W[0] first.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  WORD_W  schedule word W[out_idx].
- out_idx  out  IDX_W  round index of out_word.
- out_last  out  1  high with out_word when out_idx == ROUNDS-1.
- busy  out  1  state is not IDLE.
- abort  in  1  present only with MSG_SCHEDULE_ABORT_EN.

## Operation
- State machine:
  - IDLE: in_ready = 1. An accepted word is written to window[0] and a 4-bit load counter is set to 1; go to LOAD.
  - LOAD: in_ready = 1. Each accepted word is written to window[cnt] and cnt is incremented. The 16th accepted word (cnt == 15) moves the block to EXPAND, with round counter = 0.
  - EXPAND: in_ready = 0, out_valid = 1, out_word = window[0], out_idx = round counter. On each out_valid && out_ready:
    - window shifts down by one entry;
    - window[15] receives new = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], modulo 2^WORD_W, with carries discarded;
    - the round counter increments.
    - When the transfer has out_last high, go to IDLE.
- σ functions, where rotr is rotate right and shr is logical shift right:
  - WORD_W = 32: σ0 = rotr7 ^ rotr18 ^ shr3; σ1 = rotr17 ^ rotr19 ^ shr10.
  - WORD_W = 64: σ0 = rotr1 ^ rotr8 ^ shr7; σ1 = rotr19 ^ rotr61 ^ shr6.
- The window update is identical for every round. Words computed beyond W[ROUNDS-1] are discarded.
- Backpressure: while out_valid && !out_ready, the window, out_word, out_idx and out_last all hold.
- in_valid during EXPAND is ignored and nothing is accepted.

## Timing
- Reset values (asserted asynchronously, released synchronously to clk):
  - state = IDLE, so in_ready = 1;
  - out_valid = 0, out_word = 0, out_idx = 0, out_last = 0, busy = 0;
  - window and counters = 0.
- Load takes a minimum of 16 cycles. out_valid rises in the cycle after the 16th input handshake.
- Throughput is one word per cycle with out_ready held high. Load to last output is at minimum 16 + ROUNDS cycles.
- After the out_last handshake, the next cycle is IDLE: in_ready = 1, out_valid = 0.
- All outputs are decoded from registers; there is no combinational path from in_* to out_*.
- If rst_n is asserted mid-load or mid-expand, all state clears immediately. The partial block is discarded and no further output is produced.

## Configuration
- MSG_SCHEDULE_ABORT_EN defined:
  - adds the abort input;
  - abort sampled high in LOAD or EXPAND returns the block to IDLE on the next edge and clears the counters;
  - an output handshake in the same cycle still completes, then the abort takes effect;
  - abort in IDLE is ignored.
- MSG_SCHEDULE_ABORT_EN undefined: no abort port exists, and only rst_n cancels a block.

## Structure
- The shared package sha2_pkg holds:
  - the per-width rotate/shift constants;
  - ROUNDS per width;
  - the state enum typedef msg_sched_state_t;
  - σ0/σ1 as functions parameterised by width.
- One sub-module, msg_sched_next. It is combinational: window[14], window[9], window[1] and window[0] in, the new word out. It is instantiated once.

## Test plan
- Sigma check: load all 16 words = 0xFFFFFFFF (WORD_W = 32). Required W[16] = 0x003FFFFF + 0xFFFFFFFF + 0x1FFFFFFF + 0xFFFFFFFF mod 2^32. Bench computes this from the σ definitions.
- Padded "abc" (WORD_W = 32):
  - load W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018;
  - required W[16] = 0x61626380 and W[17] = 0x000F0000;
  - all 64 words match the bench model; out_last only at idx 63; in_ready = 1 in the cycle after.
- All-zero block, WORD_W = 64 -> exactly 80 outputs, all 0, out_idx 0..79, out_last at 79.
- Backpressure:
  - random out_ready and random in_valid gaps -> words and indices identical to the unstalled run;
  - out_word stable while stalled;
  - no input accepted during EXPAND.
- Reset mid-expand:
  - assert rst_n low at round 30 -> outputs at reset values immediately;
  - a fresh block then loads and produces the correct W[0..63].
- MSG_SCHEDULE_ABORT_EN: abort at load cnt = 9 -> IDLE next cycle; the following full block produces the correct schedule.
